// File: rtl/xor_2_exerciser_pkg.sv
// rtl/xor_2_exerciser_pkg.sv - shared state encodings and truth-table constants for the gate exerciser
package xor_2_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit i of a truth table is the gate output for row i = {a,b}.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  localparam logic [1:0] LAST_ROW = 2'd3;

endpackage

// File: rtl/xor_2_exerciser_settle_timer.sv
// rtl/xor_2_exerciser_settle_timer.sv - loadable down-counter with zero flag for the settle window
module xor_2_exerciser_settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority over decrement; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/xor_2_exerciser.sv
// rtl/xor_2_exerciser.sv - walks a 2-input gate through its truth table and checks each row
module xor_2_exerciser
  import xor_2_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECT_TT     = TT_XOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [1:0] idx_d;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0] err_count_q;
  logic [3:0] fail_vec_q;

  logic tmr_load, tmr_dec, tmr_zero;
  logic mismatch;

  assign idx_d = idx_q + 2'd1;

  // X/Z on the gate output counts as a failure, hence the case inequality.
  assign mismatch = (c !== EXPECT_TT[idx_q]);

  assign tmr_load = ((state_q == ST_IDLE) && start) ||
                    ((state_q == ST_CHECK) && (idx_q != LAST_ROW));
  assign tmr_dec  = (state_q == ST_SETTLE) && !tmr_zero;

  xor_2_exerciser_settle_timer #(
    .W(CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Run sequencer: drives a,b per row, compares c at the end of each settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SETTLE;
            idx_q       <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            err_count_q <= 3'd0;
            fail_vec_q  <= 4'd0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            fail_vec_q[idx_q] <= 1'b1;
            err_count_q       <= err_count_q + 3'd1;
          end
          if (idx_q == LAST_ROW) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
            idx_q   <= idx_d;
            a_q     <= idx_d[1];
            b_q     <= idx_d[0];
          end
        end
        ST_DONE: begin
          pass_q  <= (err_count_q == 3'd0);
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_xor_2_exerciser.sv
// tb/tb_xor_2_exerciser.sv - randomized self-checking bench for xor_2_exerciser
module tb_xor_2_exerciser;

  localparam int SETTLE = 2;
  localparam int ROW_CLKS = SETTLE + 1;
  localparam int RUN_CLKS = 4 * ROW_CLKS + 1;
  localparam logic [3:0] EXP_XOR = 4'b0110;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       c;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  logic [3:0] gate_tt;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  // Gate under test modelled as a lookup of its own truth table.
  always_comb begin
    c = gate_tt[{a, b}];
  end

  xor_2_exerciser #(
    .SETTLE_CYCLES (SETTLE),
    .EXPECT_TT     (EXP_XOR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c         (c),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_a"}, 32'(a), 32'd0);
    chk({tag, "_b"}, 32'(b), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fv"}, 32'(fail_vec), 32'd0);
  endtask

  // One full run: reference expectations come from comparing the gate's
  // truth table with XOR row by row.
  task automatic run_one(input string tag, input logic [3:0] tt, input bit mid_pulse);
    logic [3:0] exp_fv;
    int         row;
    gate_tt = tt;
    exp_fv  = tt ^ EXP_XOR;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= RUN_CLKS + 1; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (mid_pulse && k == 2 * ROW_CLKS + 1) start = 1'b1;
      if (mid_pulse && k == 2 * ROW_CLKS + 2) start = 1'b0;
      if (k <= RUN_CLKS) begin
        row = (k <= 4 * ROW_CLKS) ? (k - 1) / ROW_CLKS : 3;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ab"}, 32'({a, b}), 32'(row));
        chk({tag, "_done"}, 32'(done), 32'(k == RUN_CLKS));
      end else begin
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_ab_end"}, 32'({a, b}), 32'd3);
        chk({tag, "_fv"}, 32'(fail_vec), 32'(exp_fv));
        chk({tag, "_err"}, 32'(err_count), 32'($countones(exp_fv)));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_fv == 4'd0));
      end
    end
  endtask

  initial begin
    int done_seen;
    int first_done;
    int second_done;

    rst     = 1'b1;
    start   = 1'b0;
    gate_tt = EXP_XOR;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("after_reset");

    run_one("xor", EXP_XOR, 1'b0);
    run_one("and", 4'b1000, 1'b0);
    run_one("xor_midstart", EXP_XOR, 1'b1);

    // Reset during the CHECK cycle of row 01.
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 2 * ROW_CLKS; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("pre_abort_ab", 32'({a, b}), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_stays_idle", 32'(busy), 32'd0);
    end
    run_one("after_abort", EXP_XOR, 1'b0);

    // Start held high: runs chain back to back.
    gate_tt     = EXP_XOR;
    done_seen   = 0;
    first_done  = -1;
    second_done = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 2 * RUN_CLKS + 1) start = 1'b0;
      if (done === 1'b1) begin
        done_seen++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == RUN_CLKS + 1 || k == 2 * RUN_CLKS + 2) chk("b2b_pass", 32'(pass), 32'd1);
    end
    chk("b2b_done_count", 32'(done_seen), 32'd2);
    chk("b2b_first_done", 32'(first_done), 32'(RUN_CLKS));
    chk("b2b_spacing", 32'(second_done - first_done), 32'(RUN_CLKS + 1));
    chk("b2b_idle", 32'(busy), 32'd0);

    // Randomized gates, random idle gaps and stray start pulses.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] tt;
      tt = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_one("rand", tt, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
